// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: N-port single-word arbiter serialising timed accesses to the board SRAM.
// Define FIXED_PRIORITY_EN for lowest-index-wins arbitration; round-robin otherwise.
module sram_port_arbiter #(
  parameter int NPORTS       = 2,
  parameter int AW           = 18,
  parameter int DW           = 8,
  parameter int ACCESS_TICKS = 4
) (
  input  logic                 clock_50,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    i_req,
  input  logic [NPORTS-1:0]    i_req_we,
  input  logic [NPORTS*AW-1:0] i_req_addr,
  input  logic [NPORTS*DW-1:0] i_req_wdata,
  output logic [NPORTS-1:0]    o_ack,
  output logic [NPORTS*DW-1:0] o_rdata,
  output logic                 o_busy,
  output logic [AW-1:0]        o_m_addrbus,
  output logic [DW-1:0]        o_m_dq_out,
  output logic                 o_m_dq_oe,
  input  logic [DW-1:0]        i_m_dq_in,
  output logic                 o_m_ce_n,
  output logic                 o_m_oe_n,
  output logic                 o_m_we_n
);
  localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  localparam int TW = $clog2(ACCESS_TICKS);
  localparam logic [TW-1:0] TMAX = TW'(ACCESS_TICKS - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t r_state, w_nstate;
  logic [TW-1:0] r_tick, w_ntick;
  logic [PW-1:0] r_g, w_gnt;
  logic r_we, w_nwe;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [NPORTS*DW-1:0] r_rdata;
  logic [NPORTS-1:0] r_ack;
  logic r_busy, r_ce_n, r_oe_n, r_we_n, r_dq_oe;
`ifdef FIXED_PRIORITY_EN
  always_comb begin
    w_gnt = '0;
    for (int k = NPORTS - 1; k >= 0; k--) if (i_req[k]) w_gnt = PW'(k);
  end
`else
  logic [PW-1:0] r_rr_ptr;
  logic w_hit;
  // Two passes give the search order rr_ptr+1 .. NPORTS-1, then 0 .. rr_ptr.
  always_comb begin
    w_gnt = r_rr_ptr;
    w_hit = 1'b0;
    for (int k = 0; k < NPORTS; k++)
      if (!w_hit && i_req[k] && k > int'(r_rr_ptr)) begin
        w_gnt = PW'(k);
        w_hit = 1'b1;
      end
    for (int k = 0; k < NPORTS; k++)
      if (!w_hit && i_req[k] && k <= int'(r_rr_ptr)) begin
        w_gnt = PW'(k);
        w_hit = 1'b1;
      end
  end
  always_ff @(posedge clock_50 or negedge reset)
    if (!reset) r_rr_ptr <= PW'(NPORTS - 1);
    else if (r_state == DONE) r_rr_ptr <= r_g;
`endif
  always_ff @(posedge clock_50 or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_nstate;
  always_comb begin
    w_nstate = IDLE;
    w_ntick = r_tick - 1'b1;
    w_nwe = r_we;
    if (r_state == IDLE) begin
      w_nstate = |i_req ? ACCESS : IDLE;
      w_ntick = TMAX;
      w_nwe = i_req_we[w_gnt];
    end else if (r_state == ACCESS) w_nstate = r_tick == '0 ? DONE : ACCESS;
  end
  // Strobes are registered from the next-state view so the SRAM pins never glitch.
  always_ff @(posedge clock_50 or negedge reset)
    if (!reset) begin
      r_tick <= '0;
      r_g <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack <= '0;
      r_busy <= 1'b0;
      r_ce_n <= 1'b1;
      r_oe_n <= 1'b1;
      r_we_n <= 1'b1;
      r_dq_oe <= 1'b0;
    end else begin
      r_tick <= w_ntick;
      r_we <= w_nwe;
      if (r_state == IDLE && |i_req) begin
        r_g <= w_gnt;
        r_addr <= i_req_addr[w_gnt*AW +: AW];
        r_wdata <= i_req_wdata[w_gnt*DW +: DW];
      end
      if (r_state == ACCESS && r_tick == '0 && !r_we) r_rdata[r_g*DW +: DW] <= i_m_dq_in;
      r_ack <= w_nstate == DONE ? NPORTS'(1) << r_g : '0;
      r_busy <= w_nstate != IDLE;
      r_ce_n <= w_nstate != ACCESS;
      r_oe_n <= !(w_nstate == ACCESS && !w_nwe);
      r_dq_oe <= w_nstate == ACCESS && w_nwe;
      r_we_n <= !(w_nstate == ACCESS && w_nwe && w_ntick != TMAX && w_ntick != '0);
    end
  assign o_ack = r_ack;
  assign o_rdata = r_rdata;
  assign o_busy = r_busy;
  assign o_m_addrbus = r_addr;
  assign o_m_dq_out = r_wdata;
  assign o_m_dq_oe = r_dq_oe;
  assign o_m_ce_n = r_ce_n;
  assign o_m_oe_n = r_oe_n;
  assign o_m_we_n = r_we_n;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench with an SRAM model and an ack scoreboard.
module tb_sram_port_arbiter;
  logic clock_50 = 0, reset = 0;
  logic [1:0] req = 0, req_we = 0;
  logic [35:0] req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic [1:0] ack;
  logic [15:0] rdata;
  logic busy, dq_oe, ce_n, oe_n, we_n;
  logic [17:0] addrbus;
  logic [7:0] dq_out, dq_in;
  logic [7:0] mem [0:262143];
  logic pre_en = 0;
  logic [17:0] pre_a = 0;
  logic [7:0] pre_d = 0;
  int cyc = 0, oe_cnt = 0, we_cnt = 0, dqoe_cnt = 0, ack_tot = 0;
  int n_assert = 0, n_fail = 0, ack_cyc = 0, last_port = -1;
  typedef struct {int port; logic we; logic [7:0] data;} exp_t;
  exp_t sbq[$];

  sram_port_arbiter #(.NPORTS(2), .AW(18), .DW(8), .ACCESS_TICKS(4)) dut (
    .clock_50(clock_50), .reset(reset), .i_req(req), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_ack(ack), .o_rdata(rdata),
    .o_busy(busy), .o_m_addrbus(addrbus), .o_m_dq_out(dq_out), .o_m_dq_oe(dq_oe),
    .i_m_dq_in(dq_in), .o_m_ce_n(ce_n), .o_m_oe_n(oe_n), .o_m_we_n(we_n));

  always #10 clock_50 = ~clock_50;
  assign dq_in = mem[addrbus];
  always @(posedge clock_50) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!ce_n && !we_n && dq_oe) mem[addrbus] <= dq_out;
    cyc <= cyc + 1;
    oe_cnt <= oe_cnt + int'(!ce_n && !oe_n);
    we_cnt <= we_cnt + int'(!ce_n && !we_n);
    dqoe_cnt <= dqoe_cnt + int'(dq_oe);
    ack_tot <= ack_tot + int'(ack[0]) + int'(ack[1]);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic post(int p, logic we, logic [17:0] a, logic [7:0] d);
    req[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*18 +: 18] = a;
    req_wdata[p*8 +: 8] = d;
  endtask

  task automatic expect_ack(int p, logic we, logic [7:0] d);
    sbq.push_back('{port: p, we: we, data: d});
  endtask

  task automatic wait_ack(string tag);
    exp_t e;
    int n = 0;
    do begin
      @(negedge clock_50);
      n++;
    end while (ack == 2'b00 && n < 20);
    if (ack == 2'b00) begin
      check({tag, " ack timeout"}, 32'(ack != 0), 1);
      return;
    end
    if (sbq.size() == 0) begin
      check({tag, " unexpected ack"}, 32'(ack), 0);
      return;
    end
    e = sbq.pop_front();
    check({tag, " ack port"}, 32'(ack), 32'(1) << e.port);
    if (!e.we) check({tag, " rdata"}, 32'(rdata[e.port*8 +: 8]), 32'(e.data));
    ack_cyc = cyc;
    last_port = e.port;
    req[e.port] = 1'b0;
  endtask

  initial begin
    int c0, t0, a0, left0, left1;
    pre_en = 1; pre_a = 18'h00123; pre_d = 8'h5A;
    @(negedge clock_50);
    pre_en = 0;
    @(negedge clock_50);
    check("reset ack", 32'(ack), 0);
    check("reset rdata", 32'(rdata), 0);
    check("reset busy", 32'(busy), 0);
    check("reset strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
    check("reset dq_oe", 32'(dq_oe), 0);
    check("reset addr/dout", {6'd0, addrbus, dq_out}, 0);
    reset = 1;
    @(negedge clock_50);
    // Port 0 read
    c0 = cyc; t0 = oe_cnt;
    post(0, 0, 18'h00123, 8'h00);
    expect_ack(0, 0, 8'h5A);
    wait_ack("rd0");
    check("rd0 latency", 32'(ack_cyc - c0), 5);
    check("rd0 oe cycles", 32'(oe_cnt - t0), 4);
    @(negedge clock_50);
    check("rd0 busy after", 32'(busy), 0);
    // Port 1 write, then read back through port 0
    t0 = we_cnt; a0 = dqoe_cnt;
    post(1, 1, 18'h3FFFF, 8'hC3);
    expect_ack(1, 1, 8'h00);
    wait_ack("wr1");
    check("wr1 we cycles", 32'(we_cnt - t0), 2);
    check("wr1 dq_oe cycles", 32'(dqoe_cnt - a0), 4);
    check("wr1 model", 32'(mem[18'h3FFFF]), 32'hC3);
    @(negedge clock_50);
    check("idle addr hold", 32'(addrbus), 32'h3FFFF);
    check("idle dout hold", 32'(dq_out), 32'hC3);
    post(0, 0, 18'h3FFFF, 8'h00);
    expect_ack(0, 0, 8'hC3);
    wait_ack("rb0");
    // Simultaneous requests straight after reset
    @(negedge clock_50);
    reset = 0;
    @(negedge clock_50);
    reset = 1;
    @(negedge clock_50);
    post(0, 0, 18'h00123, 8'h00);
    post(1, 0, 18'h3FFFF, 8'h00);
    expect_ack(0, 0, 8'h5A);
    expect_ack(1, 0, 8'hC3);
    wait_ack("sim first");
    c0 = ack_cyc;
    wait_ack("sim second");
    check("sim spacing", 32'(ack_cyc - c0), 6);
    // Back-to-back re-requests
`ifdef FIXED_PRIORITY_EN
    left0 = 3; left1 = 1;
    expect_ack(0, 0, 8'h5A); expect_ack(0, 0, 8'h5A); expect_ack(0, 0, 8'h5A); expect_ack(1, 0, 8'hC3);
`else
    left0 = 2; left1 = 2;
    expect_ack(0, 0, 8'h5A); expect_ack(1, 0, 8'hC3); expect_ack(0, 0, 8'h5A); expect_ack(1, 0, 8'hC3);
`endif
    post(0, 0, 18'h00123, 8'h00);
    post(1, 0, 18'h3FFFF, 8'h00);
    for (int i = 0; i < 4; i++) begin
      wait_ack("arb");
      if (last_port == 0 && --left0 > 0) post(0, 0, 18'h00123, 8'h00);
      if (last_port == 1 && --left1 > 0) post(1, 0, 18'h3FFFF, 8'h00);
    end
    // Reset during tick 2 of a write
    @(negedge clock_50);
    post(0, 1, 18'h00200, 8'h77);
    repeat (2) @(negedge clock_50);
    check("abort we active", 32'(we_n), 0);
    reset = 0;
    #1;
    check("abort strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
    check("abort ack", 32'(ack), 0);
    check("abort busy/dq_oe", {30'd0, busy, dq_oe}, 0);
    check("abort rdata", 32'(rdata), 0);
    req = 0;
    repeat (2) @(negedge clock_50);
    reset = 1;
    @(negedge clock_50);
    post(1, 0, 18'h00123, 8'h00);
    expect_ack(1, 0, 8'h5A);
    wait_ack("post-abort rd1");
    // Port 1 drops req at tick 1 of its read
    repeat (2) @(negedge clock_50);
    t0 = ack_tot;
    post(1, 0, 18'h3FFFF, 8'h00);
    expect_ack(1, 0, 8'hC3);
    repeat (3) @(negedge clock_50);
    req[1] = 0;
    wait_ack("drop rd1");
    repeat (8) @(negedge clock_50);
    check("drop single ack", 32'(ack_tot - t0), 1);
    check("drop idle busy", 32'(busy), 0);
    check("scoreboard empty", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
